fir_stream_adapter: RTL and testbench
=====================================

# fir_stream_adapter

Stream-side companion to the FIR core. It accepts samples from an upstream valid/ready source and drives the FIR's `inputValid`/`FIR_input` pair, one sample per FIR transaction. It waits for the FIR's `outputValid`, then captures `FIR_output`, scales and narrows it, and queues it in a 2-entry result FIFO. The FIFO is drained by a downstream valid/ready sink, giving the system clean backpressure around the non-stallable FIR core.

## Interface
- `InputWidth`, 16, sample width; matches the FIR input.
- `OutputWidth`, 38, FIR accumulator width.
- `ResultWidth`, 16, width of the narrowed result.
- `FracShift`, 15, arithmetic right shift applied to `FIR_output` before narrowing; range 0..OutputWidth-ResultWidth.
- `clk`  in  1  sole clock; all logic updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  adapter can accept a sample.
- `s_data`  in  InputWidth  upstream sample, two's complement.
- `inputValid`  out  1  single-cycle start strobe to the FIR.
- `FIR_input`  out  InputWidth  registered sample presented to the FIR.
- `outputValid`  in  1  FIR result strobe.
- `FIR_output`  in  OutputWidth  FIR result, signed.
- `m_valid`  out  1  result available at the FIFO head.
- `m_ready`  in  1  downstream accepts the result.
- `m_data`  out  ResultWidth  FIFO head result.
- `result_count`  out  16  number of results pushed; wraps modulo 2^16.
- `protocol_err`  out  1  sticky; set when `outputValid` arrives outside WAIT.

## Operation
- FSM states and transitions:
  - IDLE -> ISSUE on `s_valid && s_ready`. `s_data` is registered into `FIR_input` on the same edge.
  - ISSUE -> WAIT unconditionally. `inputValid` is high in ISSUE only.
  - WAIT -> IDLE on `outputValid`. The narrowed result is pushed into the FIFO on that edge and `result_count` increments.
- `s_ready = !rst && state==IDLE && fifo_count<2`. A FIFO slot is always reserved before a sample is issued, so a push never sees a full FIFO.
- `FIR_input` is held stable from the accepting edge until the next accept.
- `outputValid` in IDLE or ISSUE is ignored for data: no push, no state change, and `protocol_err` sets. Only reset clears `protocol_err`.
- Narrowing:
  - t = `FIR_output >>> FracShift` (arithmetic shift, sign preserved).
  - result = t narrowed to ResultWidth, as selected under Configuration.
- FIFO: 2 entries, pointer-based.
  - `m_valid = fifo_count!=0`; `m_data` is the head entry, driven combinationally from FIFO storage.
  - Pop on `m_valid && m_ready`.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop with the FIFO empty has no effect.
- Reset, asserted in any state and mid-transaction included:
  - state=IDLE, FIFO emptied, `FIR_input`=0, `result_count`=0, `protocol_err`=0.
  - All outputs read 0 while `rst`=1.
  - An in-flight FIR result that arrives after reset is treated as a stray `outputValid` and sets `protocol_err`. The integrator resets the FIR core together with this block.

## Timing
- Accept edge E0 -> `inputValid` high for exactly the cycle E0..E1 -> FIR latency of L cycles -> `outputValid` sampled at edge Ek -> `m_valid` high from Ek, if the FIFO was empty.
- Sample-to-result latency through the adapter itself: 2 cycles plus the FIR latency.
- Next accept is possible in the cycle after Ek, subject to FIFO space.
- Throughput: at most 1 sample per (L+2) cycles.
- `m_data` is stable while `m_valid && !m_ready`.
- `s_ready` drops in the cycle after the accept edge and stays low until the FSM returns to IDLE.

## Configuration
- `FIR_ADAPTER_SAT_EN` defined: t is clamped to [-2^(ResultWidth-1), 2^(ResultWidth-1)-1]. A sticky `sat_flag` output (1 bit, cleared by reset) sets on every clamp.
- `FIR_ADAPTER_SAT_EN` undefined: result = low ResultWidth bits of t (wrap-around). The `sat_flag` port does not exist.

## Test plan
- Basic: reset 2 cycles, then `s_data`=0x1234 with FIR model returning `FIR_output`=0x0_4000_0000 after L=64.
  - Required: one `inputValid` pulse and `FIR_input`=0x1234.
  - Required: `m_data`=0x8000 (wrap build) or 0x7FFF with `sat_flag`=1 (SAT build).
  - Required: `result_count`=1.
- Scaling: `FIR_output`=0x0_2000_0000 -> `m_data`=0x4000. `FIR_output`=-(1<<30) -> `m_data`=0x8000 in both builds, `sat_flag` stays 0.
- Backpressure: `m_ready`=0 and 3 samples offered.
  - Required: two accepted, `s_ready` stays 0 after the 2nd result, `m_data` holds the first result.
  - Required: after raising `m_ready`, the third sample is accepted and results arrive in order.
- Simultaneous push/pop: `m_ready`=1 while the FIFO holds 1 entry and `outputValid` arrives.
  - Required: count stays 1 and the head advances to the new result.
- Stray strobe: pulse `outputValid` in IDLE.
  - Required: `protocol_err`=1, no push, `result_count` unchanged; reset clears the flag.
- Reset mid-WAIT: assert `rst` while waiting.
  - Required: all outputs 0 next cycle and the FIFO empty; `s_ready`=1 one cycle after `rst` drops.

Source files
------------

// File: rtl/fir_stream_adapter_if.sv
// Handshake bundle around fir_stream_adapter: upstream sample stream, FIR core
// strobe/data pair and downstream result stream. "slave" is the adapter's view.
interface fir_stream_adapter_if #(
  parameter int unsigned InputWidth  = 16,
  parameter int unsigned OutputWidth = 38,
  parameter int unsigned ResultWidth = 16
);
  logic                   s_valid;
  logic                   s_ready;
  logic [InputWidth-1:0]  s_data;
  logic                   inputValid;
  logic [InputWidth-1:0]  FIR_input;
  logic                   outputValid;
  logic [OutputWidth-1:0] FIR_output;
  logic                   m_valid;
  logic                   m_ready;
  logic [ResultWidth-1:0] m_data;

  modport slave (
    input  s_valid, s_data, outputValid, FIR_output, m_ready,
    output s_ready, inputValid, FIR_input, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, outputValid, FIR_output, m_ready,
    input  s_ready, inputValid, FIR_input, m_valid, m_data
  );
endinterface

// File: rtl/fir_stream_adapter.sv
// Valid/ready wrapper around a non-stallable FIR core with a 2-entry result FIFO.
// Define FIR_ADAPTER_SAT_EN for saturating narrowing and the sat_flag output.
module fir_stream_adapter #(
  parameter int unsigned InputWidth  = 16,
  parameter int unsigned OutputWidth = 38,
  parameter int unsigned ResultWidth = 16,
  parameter int unsigned FracShift   = 15
) (
  input  logic                clk,
  input  logic                rst,
  fir_stream_adapter_if.slave bus,
  output logic [15:0]         result_count,
  output logic                protocol_err
`ifdef FIR_ADAPTER_SAT_EN
  ,
  output logic                sat_flag
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]                        state_q, state_d;
  logic [InputWidth-1:0]             fir_input_q;
  logic [1:0][ResultWidth-1:0]       mem_q;
  logic                              wr_ptr_q, rd_ptr_q;
  logic [1:0]                        count_q, count_d;
  logic [15:0]                       result_count_q;
  logic                              protocol_err_q;

  logic                              s_ready_int;
  logic                              accept, push, pop, stray;
  logic signed [OutputWidth-1:0]     shifted;
  logic [ResultWidth-1:0]            narrowed;

  // A FIFO slot is reserved at accept time, so a push can never hit a full FIFO.
  assign s_ready_int = !rst && (state_q == IDLE) && (count_q != 2'd2);
  assign accept      = bus.s_valid && s_ready_int;
  assign push        = (state_q == WAIT) && bus.outputValid;
  assign stray       = (state_q != WAIT) && bus.outputValid;
  assign pop         = (count_q != 2'd0) && bus.m_ready;

  assign shifted = $signed(bus.FIR_output) >>> FracShift;

`ifdef FIR_ADAPTER_SAT_EN
  logic [OutputWidth-ResultWidth:0] hi_bits;
  logic                             ovf;
  logic                             sat_flag_q;

  // In range only if every bit from the result sign bit upward matches.
  assign hi_bits  = shifted[OutputWidth-1:ResultWidth-1];
  assign ovf      = !((&hi_bits) || !(|hi_bits));
  assign narrowed = !ovf ? shifted[ResultWidth-1:0] :
                    shifted[OutputWidth-1] ? {1'b1, {(ResultWidth-1){1'b0}}}
                                           : {1'b0, {(ResultWidth-1){1'b1}}};

  always_ff @(posedge clk) begin
    if (rst)               sat_flag_q <= 1'b0;
    else if (push && ovf)  sat_flag_q <= 1'b1;
  end

  assign sat_flag = !rst && sat_flag_q;
`else
  logic unused_hi;

  assign narrowed  = shifted[ResultWidth-1:0];
  assign unused_hi = ^shifted[OutputWidth-1:ResultWidth];
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.outputValid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      fir_input_q    <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= '0;
      result_count_q <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) fir_input_q <= bus.s_data;
      if (push) begin
        wr_ptr_q       <= !wr_ptr_q;
        result_count_q <= result_count_q + 16'd1;
      end
      if (pop)   rd_ptr_q       <= !rd_ptr_q;
      if (stray) protocol_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= narrowed;
  end

  assign bus.s_ready    = s_ready_int;
  assign bus.inputValid = !rst && (state_q == ISSUE);
  assign bus.FIR_input  = rst ? '0 : fir_input_q;
  assign bus.m_valid    = !rst && (count_q != 2'd0);
  assign bus.m_data     = rst ? '0 : mem_q[rd_ptr_q];
  assign result_count   = rst ? '0 : result_count_q;
  assign protocol_err   = !rst && protocol_err_q;

endmodule

// File: tb/tb_fir_stream_adapter.sv
// Self-checking bench for fir_stream_adapter: FIR latency model, result scoreboard,
// table-driven narrowing vectors and hand-written backpressure/reset sequences.
module tb_fir_stream_adapter;
  localparam int unsigned L = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] result_count;
  logic        protocol_err;
`ifdef FIR_ADAPTER_SAT_EN
  logic        sat_flag;
  logic        sat_exp;
`endif

  always #5 clk = ~clk;

  fir_stream_adapter_if #(.InputWidth(16), .OutputWidth(38), .ResultWidth(16)) bus ();

  fir_stream_adapter #(
    .InputWidth(16), .OutputWidth(38), .ResultWidth(16), .FracShift(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .result_count(result_count),
    .protocol_err(protocol_err)
`ifdef FIR_ADAPTER_SAT_EN
    ,
    .sat_flag(sat_flag)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int iv_pulses = 0;
  int sent      = 0;

  logic [15:0] exp_q [$];
  logic [15:0] samp_q [$];
  logic [37:0] fo_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIR core model: fixed latency L after each inputValid cycle.
  initial begin
    int          cnt;
    logic [37:0] fo_cur;
    bit          ov_mine;
    cnt = 0; fo_cur = '0; ov_mine = 0;
    forever begin
      @(negedge clk); #1;
      if (ov_mine) begin bus.outputValid = 1'b0; ov_mine = 0; end
      if (rst) cnt = 0;
      else if (bus.inputValid) begin
        iv_pulses++;
        if (samp_q.size() != 0) check("FIR_input", bus.FIR_input, samp_q.pop_front());
        else check("extra_inputValid", 1, 0);
        fo_cur = (fo_q.size() != 0) ? fo_q.pop_front() : '0;
        cnt = L;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.FIR_output  = fo_cur;
          bus.outputValid = 1'b1;
          ov_mine = 1;
        end
      end
    end
  end

  // Scoreboard: compare every popped result against the order of issue.
  initial begin
    forever begin
      @(negedge clk); #3;
      if (!rst && bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check("unexpected_pop", 1, 0);
        else check("m_data", bus.m_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(negedge clk); #2;
  endtask

  task automatic send(input logic [15:0] sample, input logic [37:0] fo, input logic [15:0] e);
    bit ok;
    ok = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = sample;
    for (int k = 0; k < 4 * L; k++) begin
      if (bus.s_ready) begin ok = 1; break; end
      cyc();
    end
    if (!ok) begin
      check("send_timeout", 0, 1);
      bus.s_valid = 1'b0;
    end else begin
      samp_q.push_back(sample);
      fo_q.push_back(fo);
      exp_q.push_back(e);
      sent++;
      cyc();
      bus.s_valid = 1'b0;
    end
  endtask

  task automatic wait_results(input int n);
    for (int k = 0; k < 4 * L; k++) begin
      if (result_count == 16'(n)) break;
      cyc();
    end
    check("result_count", result_count, 64'(n));
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 4 * L; k++) begin
      if (exp_q.size() == 0 && !bus.m_valid) break;
      cyc();
    end
    check("drain", 64'(exp_q.size()), 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    exp_q.delete(); samp_q.delete(); fo_q.delete();
    repeat (cycles) cyc();
    rst = 1'b0;
`ifdef FIR_ADAPTER_SAT_EN
    sat_exp = 1'b0;
`endif
  endtask

  typedef struct {
    logic [15:0] sample;
    logic [37:0] fir_out;
    logic [15:0] exp_wrap;
    logic [15:0] exp_sat;
    logic        clamp;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [15:0] pick(input vec_t v);
`ifdef FIR_ADAPTER_SAT_EN
    return v.exp_sat;
`else
    return v.exp_wrap;
`endif
  endfunction

  initial begin
    logic [15:0] e;
    int          base;
    vecs[0] = '{16'h0001, 38'h00_2000_0000, 16'h4000, 16'h4000, 1'b0};
    vecs[1] = '{16'hFFFF, 38'h3F_C000_0000, 16'h8000, 16'h8000, 1'b0};
    vecs[2] = '{16'h7FFF, 38'h00_0000_8000, 16'h0001, 16'h0001, 1'b0};
    vecs[3] = '{16'h8000, 38'h3F_FFFF_8000, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[4] = '{16'h00FF, 38'h3F_FFFF_FFFF, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[5] = '{16'h0F0F, 38'h00_3FFF_8000, 16'h7FFF, 16'h7FFF, 1'b0};
    vecs[6] = '{16'h1234, 38'h00_4000_0000, 16'h8000, 16'h7FFF, 1'b1};
    vecs[7] = '{16'hABCD, 38'h00_8000_0000, 16'h0000, 16'h7FFF, 1'b1};
    vecs[8] = '{16'h5555, 38'h3F_7FFF_8000, 16'hFFFF, 16'h8000, 1'b1};

    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
    bus.outputValid = 1'b0; bus.FIR_output = '0;
    repeat (2) cyc();
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_inputValid", bus.inputValid, 0);
    check("rst_FIR_input", bus.FIR_input, 0);
    do_reset(0);
    cyc();
    check("idle_s_ready", bus.s_ready, 1);
    check("idle_result_count", result_count, 0);
    check("idle_protocol_err", protocol_err, 0);

    // Narrowing table, free-flowing output.
    for (int i = 0; i < 9; i++) begin
      e = pick(vecs[i]);
      send(vecs[i].sample, vecs[i].fir_out, e);
      wait_results(i + 1);
      check("FIR_input_hold", bus.FIR_input, vecs[i].sample);
`ifdef FIR_ADAPTER_SAT_EN
      sat_exp = sat_exp | vecs[i].clamp;
      check("sat_flag", sat_flag, sat_exp);
`endif
    end
    wait_drain();
    check("inputValid_pulses", iv_pulses, sent);

    // Backpressure: two results fill the FIFO, third sample must wait.
    bus.m_ready = 1'b0;
    base = int'(result_count);
    send(16'h1111, 38'h00_0800_0000, 16'h1000);
    wait_results(base + 1);
    check("bp_m_valid", bus.m_valid, 1);
    send(16'h2222, 38'h00_1000_0000, 16'h2000);
    wait_results(base + 2);
    bus.s_valid = 1'b1; bus.s_data = 16'h3333;
    repeat (8) cyc();
    check("bp_s_ready_low", bus.s_ready, 0);
    check("bp_count_held", result_count, 64'(base + 2));
    check("bp_head_stable", bus.m_data, 16'h1000);
    check("bp_no_issue", iv_pulses, sent);
    bus.m_ready = 1'b1;
    send(16'h3333, 38'h00_1800_0000, 16'h3000);
    wait_results(base + 3);
    wait_drain();

    // Simultaneous push and pop with one entry held.
    bus.m_ready = 1'b0;
    base = int'(result_count);
    send(16'h4444, 38'h00_0001_8000, 16'h0003);
    wait_results(base + 1);
    send(16'h5555, 38'h00_0002_8000, 16'h0005);
    for (int k = 0; k < 4 * L; k++) begin
      if (bus.outputValid) break;
      cyc();
    end
    check("pp_outputValid_seen", bus.outputValid, 1);
    bus.m_ready = 1'b1;
    cyc();
    bus.m_ready = 1'b0;
    check("pp_m_valid", bus.m_valid, 1);
    check("pp_head_advanced", bus.m_data, 16'h0005);
    check("pp_result_count", result_count, 64'(base + 2));
    bus.m_ready = 1'b1;
    cyc();
    check("pp_count_was_one", bus.m_valid, 0);

    // Stray outputValid in IDLE.
    base = int'(result_count);
    bus.FIR_output = 38'h00_1234_5678;
    bus.outputValid = 1'b1;
    cyc();
    bus.outputValid = 1'b0;
    cyc();
    check("stray_protocol_err", protocol_err, 1);
    check("stray_no_push", bus.m_valid, 0);
    check("stray_count", result_count, 64'(base));
    check("stray_s_ready", bus.s_ready, 1);
    do_reset(1);
    cyc();
    check("stray_cleared", protocol_err, 0);

    // Reset while WAITing with one result queued.
    bus.m_ready = 1'b0;
    send(16'h6666, 38'h00_0000_8000, 16'h0001);
    wait_results(1);
    send(16'h7777, 38'h00_0001_0000, 16'h0002);
    repeat (10) cyc();
    rst = 1'b1;
    #1;
    check("mid_rst_s_ready", bus.s_ready, 0);
    check("mid_rst_m_valid", bus.m_valid, 0);
    check("mid_rst_m_data", bus.m_data, 0);
    check("mid_rst_FIR_input", bus.FIR_input, 0);
    check("mid_rst_count", result_count, 0);
    exp_q.delete(); samp_q.delete(); fo_q.delete();
    cyc();
    check("mid_rst_inputValid", bus.inputValid, 0);
    check("mid_rst_protocol_err", protocol_err, 0);
    rst = 1'b0;
    cyc();
    check("post_rst_s_ready", bus.s_ready, 1);
    check("post_rst_fifo_empty", bus.m_valid, 0);
    check("post_rst_count", result_count, 0);
    repeat (2 * L) cyc();
    check("post_rst_no_stray", protocol_err, 0);

    bus.m_ready = 1'b1;
    send(16'h0ACE, 38'h00_0010_0000, 16'h0020);
    wait_results(1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
